// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: producer-side write port, consumer-side read port and status.
// Signal names follow the FIFO family (winc/wfull, rinc/rempty) so existing checkers bind unchanged.
interface sync_fifo_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
);
    // A write is accepted on a rising edge where winc && !wfull; a read where rinc && !rempty.
    // wfull/rempty depend only on registered state, so a request never combinationally gates itself.
    logic             flush;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, winc, wdata, rinc,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, winc, wdata, rinc,
        output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags and flush.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; otherwise rdata is registered (latency 1).
module sync_fifo #(
    parameter int DSIZE    = 32,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 2**ASIZE - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic      clk,
    input  logic      rst,
    sync_fifo_if.slave fifo
);
    localparam int             DEPTH   = 2**ASIZE;
    localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_LEVEL);

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    logic [ASIZE:0] count;
    logic           full;
    logic           empty;
    logic           wr_en;
    logic           rd_en;

    // The extra pointer MSB makes the modular difference span 0..DEPTH without ambiguity.
    assign count = wptr_q - rptr_q;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    assign wr_en = fifo.winc && !full  && !fifo.flush;
    assign rd_en = fifo.rinc && !empty && !fifo.flush;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (fifo.flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + 1'b1;
            if (rd_en) rptr_d = rptr_q + 1'b1;
            if (fifo.winc && full)  overflow_d  = 1'b1;
            if (fifo.rinc && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[wptr_q[ASIZE-1:0]] <= fifo.wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign fifo.rdata = empty ? '0 : mem_q[rptr_q[ASIZE-1:0]];
`else
    logic [DSIZE-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) rdata_d = mem_q[rptr_q[ASIZE-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign fifo.rdata = rdata_q;
`endif

    assign fifo.count         = count;
    assign fifo.wfull         = full;
    assign fifo.rempty        = empty;
    assign fifo.walmost_full  = (count >= AF_C);
    assign fifo.ralmost_empty = (count <= AE_C);
    assign fifo.overflow      = overflow_q;
    assign fifo.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_sync_fifo;
  localparam int DSIZE = 32;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  sync_fifo #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fifo(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [DSIZE-1:0] exp_q[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic [DSIZE-1:0] m_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // model: decisions use the occupancy before the edge
  always @(posedge clk) begin : model
    bit was_full;
    bit was_empty;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    if (rst) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_rdata = '0;
    end else if (bus.flush) begin
      exp_q.delete();
    end else begin
      if (bus.winc && was_full)  m_ovf = 1'b1;
      if (bus.rinc && was_empty) m_unf = 1'b1;
      if (bus.rinc && !was_empty) m_rdata = exp_q.pop_front();
      if (bus.winc && !was_full) exp_q.push_back(bus.wdata);
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin : compare
    int n;
    if (chk_en) begin
      n = exp_q.size();
      chk("count", bus.count, n);
      chk("rempty", bus.rempty, n == 0);
      chk("wfull", bus.wfull, n == DEPTH);
      chk("walmost_full", bus.walmost_full, n >= AF);
      chk("ralmost_empty", bus.ralmost_empty, n <= AE);
      chk("overflow", bus.overflow, m_ovf);
      chk("underflow", bus.underflow, m_unf);
`ifdef SYNC_FIFO_FWFT_EN
      if (n != 0) chk("rdata_fwft", bus.rdata, exp_q[0]);
`else
      chk("rdata", bus.rdata, m_rdata);
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [DSIZE-1:0] d);
    bus.winc  = 1'b1;
    bus.wdata = d;
    tick();
    bus.winc  = 1'b0;
  endtask

  task automatic do_read(input logic [DSIZE-1:0] exp, input string name);
    bus.rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    #1;
    chk(name, bus.rdata, exp);
    tick();
`else
    tick();
    chk(name, bus.rdata, exp);
`endif
    bus.rinc = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.winc  = 1'b0;
    bus.wdata = '0;
    bus.rinc  = 1'b0;
    rst       = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();

    // reset state, literal
    chk("rst_count", bus.count, 0);
    chk("rst_rempty", bus.rempty, 1);
    chk("rst_ralmost_empty", bus.ralmost_empty, 1);
    chk("rst_wfull", bus.wfull, 0);
    chk("rst_walmost_full", bus.walmost_full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_underflow", bus.underflow, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    tick();

    // single word round trip
    do_write(32'hA);
    chk("single_count1", bus.count, 1);
    do_read(32'hA, "single_rdata");
    chk("single_count0", bus.count, 0);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      do_write(i);
      chk("fill_almost_full", bus.walmost_full, (i + 1) >= 14);
    end
    chk("fill_wfull", bus.wfull, 1);
    chk("fill_count", bus.count, 16);
    do_write(32'd99);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_count", bus.count, 16);
    for (int i = 0; i < 16; i++) do_read(i, "drain_rdata");
    chk("drain_rempty", bus.rempty, 1);

    // sustained simultaneous traffic at count 5, across pointer wrap
    for (int i = 0; i < 5; i++) do_write(100 + i);
    for (int j = 0; j < 40; j++) begin
      bus.winc  = 1'b1;
      bus.rinc  = 1'b1;
      bus.wdata = 105 + j;
      tick();
    end
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    chk("stream_count", bus.count, 5);
    for (int i = 0; i < 5; i++) do_read(140 + i, "stream_tail");
    chk("pre_unf_flag", bus.underflow, 0);

    // read while empty with simultaneous write
    bus.winc  = 1'b1;
    bus.wdata = 32'h77;
    bus.rinc  = 1'b1;
    tick();
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    chk("unf_flag", bus.underflow, 1);
    chk("unf_count", bus.count, 1);
    do_read(32'h77, "unf_next_read");

    // flush with a concurrent write
    for (int i = 0; i < 9; i++) do_write(200 + i);
    chk("pre_flush_count", bus.count, 9);
    bus.flush = 1'b1;
    bus.winc  = 1'b1;
    bus.wdata = 32'hDEAD;
    tick();
    bus.flush = 1'b0;
    bus.winc  = 1'b0;
    chk("flush_count", bus.count, 0);
    chk("flush_rempty", bus.rempty, 1);
    chk("flush_overflow", bus.overflow, 1);
    chk("flush_underflow", bus.underflow, 1);
    do_write(32'h55);
    do_read(32'h55, "post_flush_rdata");

    // randomized traffic in biased phases, with occasional flush and reset
    for (int c = 0; c < 4000; c++) begin
      int wb;
      case ((c / 400) % 3)
        0:       wb = 80;
        1:       wb = 20;
        default: wb = 50;
      endcase
      bus.winc  = ($urandom_range(99, 0) < wb);
      bus.rinc  = ($urandom_range(99, 0) < (100 - wb));
      bus.wdata = $urandom;
      bus.flush = ($urandom_range(149, 0) == 0);
      rst       = ($urandom_range(999, 0) == 0);
      tick();
    end
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.flush = 1'b0;
    rst       = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
